// File: rtl/split_parallel_to_serial.sv
// Splits one parallel word into two fields and serializes each field LSB-first
// on its own independently back-pressured 1-bit valid/ready lane.
module split_parallel_to_serial #(
    parameter int unsigned WIDTH_1  = 3,
    parameter int unsigned WIDTH_2  = 8,
    parameter int unsigned IN_WIDTH = WIDTH_1 + WIDTH_2
) (
    input  logic                clk,
    input  logic                aresetn,

    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_WIDTH-1:0] s_data,

    output logic                m_valid_1,
    input  logic                m_ready_1,
    output logic                m_data_1,

    output logic                m_valid_2,
    input  logic                m_ready_2,
    output logic                m_data_2
);

    localparam int unsigned CW1 = $clog2(WIDTH_1 + 1);
    localparam int unsigned CW2 = $clog2(WIDTH_2 + 1);

    logic [WIDTH_1-1:0] r_sh_1;
    logic [WIDTH_2-1:0] r_sh_2;
    logic [CW1-1:0]     r_cnt_1;
    logic [CW2-1:0]     r_cnt_2;

    logic w_free_1;
    logic w_free_2;
    logic w_fire_1;
    logic w_fire_2;
    logic w_accept;

    // A lane is free when idle or when its last bit leaves this cycle.
    always_comb begin
        w_free_1 = (r_cnt_1 == '0) | ((r_cnt_1 == CW1'(1)) & m_ready_1);
        w_free_2 = (r_cnt_2 == '0) | ((r_cnt_2 == CW2'(1)) & m_ready_2);
        w_fire_1 = (r_cnt_1 != '0) & m_ready_1;
        w_fire_2 = (r_cnt_2 != '0) & m_ready_2;
        w_accept = s_valid & w_free_1 & w_free_2;
    end

    assign s_ready   = w_free_1 & w_free_2;
    assign m_valid_1 = (r_cnt_1 != '0);
    assign m_data_1  = r_sh_1[0];
    assign m_valid_2 = (r_cnt_2 != '0);
    assign m_data_2  = r_sh_2[0];

    // Lane 1: a new load wins over the same-cycle last-bit shift.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sh_1  <= '0;
            r_cnt_1 <= '0;
        end else if (w_accept) begin
            r_sh_1  <= s_data[IN_WIDTH-1:WIDTH_2];
            r_cnt_1 <= CW1'(WIDTH_1);
        end else if (w_fire_1) begin
            r_sh_1  <= r_sh_1 >> 1;
            r_cnt_1 <= r_cnt_1 - CW1'(1);
        end
    end

    // Lane 2: same structure on the lower field.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sh_2  <= '0;
            r_cnt_2 <= '0;
        end else if (w_accept) begin
            r_sh_2  <= s_data[WIDTH_2-1:0];
            r_cnt_2 <= CW2'(WIDTH_2);
        end else if (w_fire_2) begin
            r_sh_2  <= r_sh_2 >> 1;
            r_cnt_2 <= r_cnt_2 - CW2'(1);
        end
    end

endmodule

// File: doc/split_parallel_to_serial.md
Name: split_parallel_to_serial

Overview:
- Inverse of the two-lane serial-to-parallel merge path. Accepts one parallel word of WIDTH_1+WIDTH_2 bits over a valid/ready handshake.
- Splits the word into two fields and serializes each field on its own 1-bit valid/ready output lane.
- Lanes drain independently, so each downstream serial slave applies its own backpressure.
- The next word is accepted only when both lanes can take it.

Parameters:
- WIDTH_1, 3: width of field 1 (upper bits of s_data); must be >= 1.
- WIDTH_2, 8: width of field 2 (lower bits of s_data); must be >= 1.
- IN_WIDTH, WIDTH_1 + WIDTH_2: parallel input width; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_valid  input  1  parallel word valid.
- s_ready  output  1  block accepts the word this cycle.
- s_data  input  IN_WIDTH  parallel word; field 1 = s_data[IN_WIDTH-1:WIDTH_2], field 2 = s_data[WIDTH_2-1:0].
- m_valid_1  output  1  lane 1 serial bit valid.
- m_ready_1  input  1  lane 1 slave ready.
- m_data_1  output  1  lane 1 serial bit.
- m_valid_2  output  1  lane 2 serial bit valid.
- m_ready_2  input  1  lane 2 slave ready.
- m_data_2  output  1  lane 2 serial bit.

Behaviour:
- One clock (clk); reset asynchronous, active-low (aresetn).
- Per lane x: shift register sh_x[WIDTH_x-1:0] and remaining-bit counter cnt_x (0..WIDTH_x, width $clog2(WIDTH_x+1)).
- While aresetn=0, all registers clear: cnt_x=0, sh_x=0, so m_valid_x=0 and m_data_x=0. s_ready is combinational and reads 1 from reset deassertion.
- Reset mid-word discards both lanes' remaining bits; no partial output resumes.
- Lane outputs: m_valid_x = (cnt_x != 0); m_data_x = sh_x[0]. Bits go out LSB first.
- Lane fire: on an edge with m_valid_x & m_ready_x, sh_x shifts right by one (zero fill) and cnt_x decrements.
- s_ready = free_1 & free_2, where free_x = (cnt_x == 0) | (cnt_x == 1 & m_ready_x). This allows back-to-back words with no bubble. s_ready must not depend on s_valid.
- Accept: on an edge with s_valid & s_ready, sh_1 loads field 1, sh_2 loads field 2, and cnt_1=WIDTH_1, cnt_2=WIDTH_2. Load takes priority over the same-cycle last-bit shift.
- Latency: word accepted at edge N gives m_valid_1 = m_valid_2 = 1 in cycle N+1, with bit 0 of each field presented.
- Minimum word period = max(WIDTH_1, WIDTH_2) cycles when both slaves are always ready.
- Stability: while m_valid_x & !m_ready_x, m_valid_x and m_data_x hold.
- Once raised, m_valid_x stays high until its lane's last bit fires. The shorter lane idles (m_valid_x=0) until the next accept.
- Lane x is never reloaded while cnt_x>1; no bit is dropped or duplicated.
- A lane stalled indefinitely blocks s_ready; the other lane still drains its remaining bits.
- s_data is ignored when s_valid=0 or s_ready=0.
- No state machine beyond the per-lane counters. The idle/shifting/last-bit states are encoded as cnt_x==0, cnt_x>1 and cnt_x==1.

Test Plan:
- Reset, then idle: aresetn low 3 cycles, then high → m_valid_1=m_valid_2=0, m_data_x=0, s_ready=1.
- Single word, both slaves always ready (WIDTH_1=3, WIDTH_2=8): s_data=11'b101_1100_0011 → lane 1 emits 1,0,1 in cycles 1-3; lane 2 emits 1,1,0,0,0,0,1,1 in cycles 1-8; s_ready=0 in cycles 1-7 and returns to 1 in cycle 8.
- Back-to-back words, s_valid held high, words 11'h5A3 then 11'h0FF → second word accepted at the edge ending lane 2's last bit. Lane 2 shows no idle cycle: 1,1,0,0,0,1,0,1 then 1,1,1,1,1,1,1,1. Lane 1 emits 1,0,1 then idles cycles 4-8, then emits 0,0,0.
- Backpressure: m_ready_2 toggled 1,0,0,1,... mid-word → m_data_2 and m_valid_2 stable during stalls; lane 1 completes unaffected; s_ready waits for lane 2's last bit to fire.
- Lane 1 stall: m_ready_1=0 for 20 cycles after accept → lane 2 finishes 8 bits; s_ready stays 0; lane 1 holds bit 0 until m_ready_1 rises.
- Async reset mid-word: aresetn pulled low after lane 2 emitted 4 bits → m_valid_x drop immediately without waiting for clk. After release, a new word serializes from its own bit 0.
